// File: rtl/qkv_issue_stream.sv
// Streams Q rows and paired K/V rows from synchronous SRAMs onto three vld/rdy channels.
// Each Q row is followed by KV_ROWS K/V pairs; the sequence repeats num_q times.
module qkv_issue_stream #(
    parameter int KV_ROWS    = 8,
    parameter int MAX_Q_ROWS = 8,
    parameter int KV_DEPTH   = 2,
    parameter int Q_W        = 32,
    parameter int K_W        = 32,
    parameter int V_W        = 32
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic [$clog2(MAX_Q_ROWS):0]   num_q,
    output logic                          busy,
    output logic                          done,
    output logic                          q_rd_en,
    output logic [$clog2(MAX_Q_ROWS)-1:0] q_rd_addr,
    input  logic [Q_W-1:0]                q_rd_data,
    output logic                          kv_rd_en,
    output logic [$clog2(KV_ROWS)-1:0]    kv_rd_addr,
    input  logic [K_W-1:0]                k_rd_data,
    input  logic [V_W-1:0]                v_rd_data,
    output logic                          Q_vld_out,
    input  logic                          Q_rdy_in,
    output logic [Q_W-1:0]                q_out,
    output logic                          K_vld_out,
    input  logic                          K_rdy_in,
    output logic [K_W-1:0]                k_out,
    output logic                          V_vld_out,
    input  logic                          V_rdy_in,
    output logic [V_W-1:0]                v_out
);

    localparam int QA_W = $clog2(MAX_Q_ROWS);
    localparam int KA_W = $clog2(KV_ROWS);
    localparam int NQ_W = QA_W + 1;
    localparam int KC_W = $clog2(MAX_Q_ROWS * KV_ROWS + 1);
    localparam int PW   = (KV_DEPTH > 1) ? $clog2(KV_DEPTH) : 1;
    localparam int OW   = $clog2(KV_DEPTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    logic            run;
    logic            launch;
    logic            zero_start;
    logic            zero_done;

    logic [NQ_W-1:0] nq;
    logic [NQ_W-1:0] q_cnt;
    logic            q_infl;
    logic            q_vld;
    logic [Q_W-1:0]  q_data;
    logic            q_left;
    logic            q_hs;

    logic [KC_W-1:0] kv_total;
    logic [KC_W-1:0] kv_cnt;
    logic [KA_W-1:0] kv_addr;
    logic            kv_infl;
    logic            kv_left;
    logic            kv_ok;
    logic [OW:0]     kv_used;

    logic [K_W-1:0]  k_mem [KV_DEPTH];
    logic [V_W-1:0]  v_mem [KV_DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [OW-1:0]   occ;
    logic            k_taken;
    logic            v_taken;
    logic            k_hs;
    logic            v_hs;
    logic            push;
    logic            pop;
    logic            finishing;

    // FSM: state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM: next state
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (launch) state_nxt = RUN;
            RUN:     if (finishing) state_nxt = FIN;
            FIN:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        run  = (state == RUN);
        busy = (state == RUN) || (state == FIN);
        done = (state == FIN) || zero_done;
    end

    assign launch     = (state == IDLE) && start && (num_q != '0);
    assign zero_start = (state == IDLE) && start && (num_q == '0);

    assign q_left   = (q_cnt < nq);
    assign kv_total = KC_W'(nq) * KC_W'(KV_ROWS);
    assign kv_left  = (kv_cnt < kv_total);

    assign q_hs      = q_vld && Q_rdy_in;
    assign K_vld_out = (occ != '0) && !k_taken;
    assign V_vld_out = (occ != '0) && !v_taken;
    assign k_hs      = K_vld_out && K_rdy_in;
    assign v_hs      = V_vld_out && V_rdy_in;
    assign pop       = (k_taken || k_hs) && (v_taken || v_hs);
    assign push      = kv_infl;

    // A read already in flight holds a FIFO slot; a same-cycle pop frees one.
    assign kv_used = {1'b0, occ} + (OW + 1)'(kv_infl) - (OW + 1)'(pop);
    assign kv_ok   = (kv_used < (OW + 1)'(KV_DEPTH));

    assign q_rd_en    = run && q_left && !q_infl && (!q_vld || Q_rdy_in);
    assign kv_rd_en   = run && kv_left && kv_ok;
    assign q_rd_addr  = q_cnt[QA_W-1:0];
    assign kv_rd_addr = kv_addr;

    assign finishing = !q_left && !kv_left && !q_infl && !kv_infl
                     && (!q_vld || q_hs)
                     && ((occ - OW'(pop)) == '0);

    assign Q_vld_out = q_vld;
    assign q_out     = q_data;
    assign k_out     = k_mem[rd_ptr];
    assign v_out     = v_mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            zero_done <= 1'b0;
            nq        <= '0;
            q_cnt     <= '0;
            kv_cnt    <= '0;
            kv_addr   <= '0;
            q_infl    <= 1'b0;
            kv_infl   <= 1'b0;
            q_vld     <= 1'b0;
            q_data    <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            occ       <= '0;
            k_taken   <= 1'b0;
            v_taken   <= 1'b0;
            for (int i = 0; i < KV_DEPTH; i++) begin
                k_mem[i] <= '0;
                v_mem[i] <= '0;
            end
        end else begin
            zero_done <= zero_start;
            q_infl    <= q_rd_en;
            kv_infl   <= kv_rd_en;

            if (launch) begin
                nq      <= num_q;
                q_cnt   <= '0;
                kv_cnt  <= '0;
                kv_addr <= '0;
            end else begin
                if (q_rd_en) begin
                    q_cnt <= q_cnt + 1'b1;
                end
                if (kv_rd_en) begin
                    kv_cnt  <= kv_cnt + 1'b1;
                    kv_addr <= (kv_addr == KA_W'(KV_ROWS - 1)) ? '0 : kv_addr + 1'b1;
                end
            end

            if (q_infl) begin
                q_data <= q_rd_data;
                q_vld  <= 1'b1;
            end else if (q_hs) begin
                q_vld <= 1'b0;
            end

            if (push) begin
                k_mem[wr_ptr] <= k_rd_data;
                v_mem[wr_ptr] <= v_rd_data;
                wr_ptr <= (wr_ptr == PW'(KV_DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == PW'(KV_DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            end
            occ <= occ + OW'(push) - OW'(pop);

            // Taken flags let K and V drain the shared head independently.
            if (pop) begin
                k_taken <= 1'b0;
                v_taken <= 1'b0;
            end else begin
                if (k_hs) k_taken <= 1'b1;
                if (v_hs) v_taken <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_qkv_issue_stream.sv
// Bench for qkv_issue_stream: SRAM models, a stream scoreboard, directed
// latency/corner sequences and a table of randomized-handshake runs.
module tb_qkv_issue_stream;

    localparam int KVR = 4;
    localparam int MQ  = 8;
    localparam int KVD = 2;
    localparam int W   = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [3:0]   num_q;
    logic         busy;
    logic         done;
    logic         q_rd_en;
    logic [2:0]   q_rd_addr;
    logic [W-1:0] q_rd_data;
    logic         kv_rd_en;
    logic [1:0]   kv_rd_addr;
    logic [W-1:0] k_rd_data;
    logic [W-1:0] v_rd_data;
    logic         Q_vld_out;
    logic         Q_rdy_in;
    logic [W-1:0] q_out;
    logic         K_vld_out;
    logic         K_rdy_in;
    logic [W-1:0] k_out;
    logic         V_vld_out;
    logic         V_rdy_in;
    logic [W-1:0] v_out;

    logic [W-1:0] qmem [MQ];
    logic [W-1:0] kmem [KVR];
    logic [W-1:0] vmem [KVR];

    int nvec = 0;
    int nerr = 0;
    bit mon_en;
    int q_n, k_n, v_n, qr_n, kvr_n, done_n;
    logic pq_vld, pq_hs, pk_vld, pk_hs, pv_vld, pv_hs;
    logic [W-1:0] pq, pk, pv;

    typedef struct {
        int nq;
        int qp;
        int kp;
        int vp;
        int exp_q;
        int exp_kv;
    } vec_t;

    qkv_issue_stream #(
        .KV_ROWS    (KVR),
        .MAX_Q_ROWS (MQ),
        .KV_DEPTH   (KVD),
        .Q_W        (W),
        .K_W        (W),
        .V_W        (W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .num_q      (num_q),
        .busy       (busy),
        .done       (done),
        .q_rd_en    (q_rd_en),
        .q_rd_addr  (q_rd_addr),
        .q_rd_data  (q_rd_data),
        .kv_rd_en   (kv_rd_en),
        .kv_rd_addr (kv_rd_addr),
        .k_rd_data  (k_rd_data),
        .v_rd_data  (v_rd_data),
        .Q_vld_out  (Q_vld_out),
        .Q_rdy_in   (Q_rdy_in),
        .q_out      (q_out),
        .K_vld_out  (K_vld_out),
        .K_rdy_in   (K_rdy_in),
        .k_out      (k_out),
        .V_vld_out  (V_vld_out),
        .V_rdy_in   (V_rdy_in),
        .v_out      (v_out)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (q_rd_en) q_rd_data <= qmem[q_rd_addr];
        if (kv_rd_en) begin
            k_rd_data <= kmem[kv_rd_addr];
            v_rd_data <= vmem[kv_rd_addr];
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: n-th Q accepted is row n, n-th K/V accepted is row n mod KVR.
    task automatic mon();
        int pairs;
        int outst;
        if (!mon_en) return;
        if (pq_vld && !pq_hs) chk("q_hold", 32'({Q_vld_out, q_out}), 32'({1'b1, pq}));
        if (pk_vld && !pk_hs) chk("k_hold", 32'({K_vld_out, k_out}), 32'({1'b1, pk}));
        if (pv_vld && !pv_hs) chk("v_hold", 32'({V_vld_out, v_out}), 32'({1'b1, pv}));
        if (q_rd_en) begin
            chk("q_addr", 32'(q_rd_addr), qr_n);
            qr_n++;
        end
        if (kv_rd_en) begin
            chk("kv_addr", 32'(kv_rd_addr), kvr_n % KVR);
            kvr_n++;
        end
        if (Q_vld_out && Q_rdy_in) begin
            chk("q_data", 32'(q_out), 32'(qmem[q_n % MQ]));
            q_n++;
        end
        if (K_vld_out && K_rdy_in) begin
            chk("k_data", 32'(k_out), 32'(kmem[k_n % KVR]));
            k_n++;
        end
        if (V_vld_out && V_rdy_in) begin
            chk("v_data", 32'(v_out), 32'(vmem[v_n % KVR]));
            v_n++;
        end
        pairs = (k_n < v_n) ? k_n : v_n;
        outst = kvr_n - pairs;
        nvec++;
        if (outst > KVD) begin
            nerr++;
            $display("FAIL kv_outstanding: got %0d expected <= %0d", outst, KVD);
        end
        if (done) done_n++;
        pq_vld = Q_vld_out; pq_hs = Q_vld_out && Q_rdy_in; pq = q_out;
        pk_vld = K_vld_out; pk_hs = K_vld_out && K_rdy_in; pk = k_out;
        pv_vld = V_vld_out; pv_hs = V_vld_out && V_rdy_in; pv = v_out;
    endtask

    task automatic mid();
        @(negedge clk);
        mon();
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic cyc();
        mid();
        nxt();
    endtask

    task automatic set_rdy(input logic q, input logic k, input logic v);
        Q_rdy_in = q;
        K_rdy_in = k;
        V_rdy_in = v;
    endtask

    task automatic do_start(input int n);
        q_n = 0; k_n = 0; v_n = 0; qr_n = 0; kvr_n = 0; done_n = 0;
        pq_vld = 0; pk_vld = 0; pv_vld = 0;
        pq_hs = 0; pk_hs = 0; pv_hs = 0;
        start = 1'b1;
        num_q = 4'(n);
        cyc();
        start = 1'b0;
    endtask

    task automatic run_to_done(input int budget, input int qp, input int kp, input int vp);
        int c = 0;
        while (done_n == 0 && c < budget) begin
            Q_rdy_in = ($urandom_range(99) < qp);
            K_rdy_in = ($urandom_range(99) < kp);
            V_rdy_in = ($urandom_range(99) < vp);
            cyc();
            c++;
        end
        chk("done_seen", done_n, 1);
        set_rdy(1, 1, 1);
        repeat (3) cyc();
    endtask

    task automatic finish_run(input int eq, input int ekv);
        chk("q_count", q_n, eq);
        chk("k_count", k_n, ekv);
        chk("v_count", v_n, ekv);
        chk("q_reads", qr_n, eq);
        chk("kv_reads", kvr_n, ekv);
        chk("done_once", done_n, 1);
        chk("idle_busy", 32'(busy), 0);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_ctl"}, 32'({busy, done, q_rd_en, kv_rd_en, Q_vld_out, K_vld_out, V_vld_out}), 0);
        chk({tag, "_addr"}, 32'({q_rd_addr, kv_rd_addr}), 0);
        chk({tag, "_q"}, 32'(q_out), 0);
        chk({tag, "_k"}, 32'(k_out), 0);
        chk({tag, "_v"}, 32'(v_out), 0);
    endtask

    initial begin
        vec_t tbl[6];
        tbl[0] = '{1, 100, 100, 100, 1, 4};
        tbl[1] = '{2, 100, 100, 100, 2, 8};
        tbl[2] = '{3, 50, 70, 30, 3, 12};
        tbl[3] = '{8, 30, 30, 90, 8, 32};
        tbl[4] = '{5, 80, 20, 60, 5, 20};
        tbl[5] = '{7, 10, 90, 50, 7, 28};

        for (int i = 0; i < MQ; i++) qmem[i] = W'($urandom);
        for (int i = 0; i < KVR; i++) begin
            kmem[i] = W'($urandom);
            vmem[i] = W'($urandom);
        end

        mon_en = 0;
        rst = 1'b1;
        start = 1'b0;
        num_q = '0;
        set_rdy(0, 0, 0);
        repeat (3) nxt();
        mid();
        chk_zero("reset");
        nxt();
        rst = 1'b0;
        nxt();

        // Latency and back-to-back pairs, num_q=1
        mon_en = 1;
        set_rdy(1, 1, 1);
        do_start(1);
        mid();
        chk("c1_q_rd", 32'({q_rd_en, q_rd_addr}), 32'({1'b1, 3'd0}));
        chk("c1_kv_rd", 32'({kv_rd_en, kv_rd_addr}), 32'({1'b1, 2'd0}));
        chk("c1_busy_vld", 32'({busy, Q_vld_out, K_vld_out}), 32'(3'b100));
        nxt();
        mid();
        chk("c2_rd", 32'({q_rd_en, kv_rd_en, kv_rd_addr}), 32'({1'b0, 1'b1, 2'd1}));
        chk("c2_vld", 32'({Q_vld_out, K_vld_out, V_vld_out}), 0);
        nxt();
        mid();
        chk("c3_vld", 32'({Q_vld_out, K_vld_out, V_vld_out}), 32'(3'b111));
        chk("c3_kv_rd", 32'({kv_rd_en, kv_rd_addr}), 32'({1'b1, 2'd2}));
        nxt();
        mid();
        chk("c4_kv_rd", 32'({kv_rd_en, kv_rd_addr}), 32'({1'b1, 2'd3}));
        chk("c4_q_vld", 32'(Q_vld_out), 0);
        nxt();
        mid();
        chk("c5_kv_rd", 32'(kv_rd_en), 0);
        nxt();
        mid();
        chk("c6_done", 32'(done), 0);
        nxt();
        mid();
        chk("c7_done", 32'({done, busy, K_vld_out}), 32'(3'b110));
        nxt();
        mid();
        chk("c8_idle", 32'({done, busy}), 0);
        nxt();
        finish_run(1, 4);

        // K taken at t=3, V taken at t+3
        set_rdy(1, 0, 0);
        do_start(1);
        cyc();
        cyc();
        K_rdy_in = 1'b1;
        mid();
        chk("skew_k_t", 32'(K_vld_out), 1);
        nxt();
        for (int c = 1; c <= 3; c++) begin
            if (c == 3) V_rdy_in = 1'b1;
            mid();
            chk("skew_k_low", 32'(K_vld_out), 0);
            chk("skew_v_high", 32'({V_vld_out, v_out}), 32'({1'b1, vmem[0]}));
            nxt();
        end
        mid();
        chk("skew_next_k", 32'({K_vld_out, k_out}), 32'({1'b1, kmem[1]}));
        chk("skew_next_v", 32'({V_vld_out, v_out}), 32'({1'b1, vmem[1]}));
        nxt();
        run_to_done(200, 100, 100, 100);
        finish_run(1, 4);

        // start while busy is ignored
        set_rdy(1, 1, 1);
        do_start(1);
        cyc();
        start = 1'b1;
        num_q = 4'd3;
        cyc();
        start = 1'b0;
        run_to_done(200, 100, 100, 100);
        finish_run(1, 4);

        // num_q=0: done next cycle, no reads
        do_start(0);
        mid();
        chk("zero_done", 32'({done, busy, q_rd_en, kv_rd_en}), 32'(4'b1000));
        nxt();
        mid();
        chk("zero_after", 32'({done, busy, q_rd_en, kv_rd_en}), 0);
        nxt();

        // Q row 1 held by back-pressure
        set_rdy(1, 1, 1);
        do_start(2);
        for (int c = 0; c < 20 && q_n == 0; c++) cyc();
        Q_rdy_in = 1'b0;
        repeat (10) cyc();
        mid();
        chk("q1_held", 32'({Q_vld_out, q_out}), 32'({1'b1, qmem[1]}));
        chk("q1_busy", 32'(busy), 1);
        nxt();
        run_to_done(200, 100, 100, 100);
        finish_run(2, 8);

        // K/V stalled 5 cycles mid-stream
        set_rdy(1, 1, 1);
        do_start(2);
        repeat (4) cyc();
        set_rdy(1, 0, 0);
        repeat (5) cyc();
        run_to_done(200, 100, 100, 100);
        finish_run(2, 8);

        // Randomized handshakes against the scoreboard
        for (int i = 0; i < 6; i++) begin
            set_rdy(1, 1, 1);
            do_start(tbl[i].nq);
            run_to_done(3000, tbl[i].qp, tbl[i].kp, tbl[i].vp);
            finish_run(tbl[i].exp_q, tbl[i].exp_kv);
        end

        // rst mid-run, then clean restart
        mon_en = 0;
        set_rdy(1, 1, 1);
        do_start(2);
        repeat (3) cyc();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        mid();
        chk_zero("midrst");
        nxt();
        mon_en = 1;
        do_start(1);
        mid();
        chk("restart_rd", 32'({q_rd_en, q_rd_addr, kv_rd_en, kv_rd_addr}),
            32'({1'b1, 3'd0, 1'b1, 2'd0}));
        nxt();
        run_to_done(200, 100, 100, 100);
        finish_run(1, 4);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
